frame_composer: RTL and testbench

FRAME_COMPOSER -- requirements
Module: frame_composer

---
 rtl/frame_composer.sv | 196 +++++++++++++++++++
 tb/tb_frame_composer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_composer.sv
// rtl/frame_composer.sv - double-buffered 128x64 LCD frame store with read-modify-write blits
//
// Ports:
//   clk, rstn                 clock; asynchronous active-low reset
//   blit_valid_i/blit_ready_o blit handshake (accepted when both high)
//   blit_col_i, blit_page_i   target column 0..127 and 8-pixel page 0..7
//   blit_data_i, blit_op_i    pixel byte; op 00 write, 01 OR, 10 XOR, 11 clear-bits
//   frame_done_i              pulse requesting a front/back swap
//   rd_addr_i, rd_data_o      LCD driver read port on the front bank, 1-cycle latency
//   start_o                   4-cycle LCD driver start pulse after each swap
//   front_sel_o               bank currently displayed
//
// Build option: FB_CLEAR_ON_SWAP_EN zeroes the new back bank after every swap.

module frame_composer #(
    parameter int unsigned LOCK_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       blit_valid_i,
    output logic       blit_ready_o,
    input  logic [6:0] blit_col_i,
    input  logic [2:0] blit_page_i,
    input  logic [7:0] blit_data_i,
    input  logic [1:0] blit_op_i,
    input  logic       frame_done_i,
    input  logic [9:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       start_o,
    output logic       front_sel_o
);

    localparam int LOCK_W = ($clog2(LOCK_CYCLES + 1) > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_READY,
        ST_RMW,
        ST_SWAP,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       cnt_q, cnt_d;
    logic              front_sel_q, front_sel_d;
    logic              swap_pending_q, swap_pending_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [2:0]        start_cnt_q, start_cnt_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [9:0]        rmw_addr_q, rmw_addr_d;
    logic [7:0]        rmw_data_q, rmw_data_d;
    logic [1:0]        rmw_op_q, rmw_op_d;
    logic [7:0]        rmw_old_q, rmw_old_d;

    logic [7:0] bank0_mem [0:1023];
    logic [7:0] bank1_mem [0:1023];

    logic       wr_en;
    logic       wr_bank;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] blit_addr;
    logic [7:0] back_byte;
    logic [7:0] front_byte;
    logic       swap_ok;

    assign blit_addr  = {blit_col_i[6], blit_page_i, blit_col_i[5:0]};
    assign back_byte  = front_sel_q ? bank0_mem[blit_addr] : bank1_mem[blit_addr];
    assign front_byte = front_sel_q ? bank1_mem[rd_addr_i] : bank0_mem[rd_addr_i];

    // The decision is taken in READY one cycle before SWAP; a count of 1 here
    // reaches 0 on the same edge that enters SWAP, so consecutive swaps are
    // exactly LOCK_CYCLES apart.
    assign swap_ok = swap_pending_q && (lock_q <= LOCK_W'(1));

    assign blit_ready_o = (state_q == ST_READY) && !swap_ok;
    assign rd_data_o    = rd_data_q;
    assign start_o      = (start_cnt_q != 3'd0);
    assign front_sel_o  = front_sel_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q | frame_done_i;
        lock_d         = (lock_q != '0) ? lock_q - LOCK_W'(1) : '0;
        start_cnt_d    = (start_cnt_q != 3'd0) ? start_cnt_q - 3'd1 : 3'd0;
        rd_data_d      = front_byte;
        rmw_addr_d     = rmw_addr_q;
        rmw_data_d     = rmw_data_q;
        rmw_op_d       = rmw_op_q;
        rmw_old_d      = rmw_old_q;
        wr_en          = 1'b0;
        wr_bank        = ~front_sel_q;
        wr_addr        = rmw_addr_q;
        wr_data        = 8'h00;

        case (state_q)
            ST_INIT: begin
                // One byte per cycle; cnt_q[10] walks bank 0 then bank 1.
                wr_en   = 1'b1;
                wr_bank = cnt_q[10];
                wr_addr = cnt_q[9:0];
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q == 11'd2047) begin
                    cnt_d   = 11'd0;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (swap_ok) begin
                    state_d = ST_SWAP;
                    lock_d  = LOCK_W'(LOCK_CYCLES);
                end else if (blit_valid_i) begin
                    rmw_addr_d = blit_addr;
                    rmw_data_d = blit_data_i;
                    rmw_op_d   = blit_op_i;
                    rmw_old_d  = back_byte;
                    state_d    = ST_RMW;
                end
            end
            ST_RMW: begin
                wr_en = 1'b1;
                case (rmw_op_q)
                    2'b00:   wr_data = rmw_data_q;
                    2'b01:   wr_data = rmw_old_q | rmw_data_q;
                    2'b10:   wr_data = rmw_old_q ^ rmw_data_q;
                    default: wr_data = rmw_old_q & ~rmw_data_q;
                endcase
                state_d = ST_READY;
            end
            ST_SWAP: begin
                front_sel_d    = ~front_sel_q;
                // A pulse landing in the swap cycle itself is kept for the next swap.
                swap_pending_d = frame_done_i;
                start_cnt_d    = 3'd4;
`ifdef FB_CLEAR_ON_SWAP_EN
                cnt_d          = 11'd0;
                state_d        = ST_CLEAR;
`else
                state_d        = ST_READY;
`endif
            end
            ST_CLEAR: begin
                // front_sel_q already points at the new front, so the default
                // wr_bank selects the new back bank.
                wr_en   = 1'b1;
                wr_addr = cnt_q[9:0];
                cnt_d   = cnt_q + 11'd1;
                if (cnt_q[9:0] == 10'd1023) begin
                    cnt_d   = 11'd0;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_INIT;
            cnt_q          <= 11'd0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            lock_q         <= '0;
            start_cnt_q    <= 3'd0;
            rd_data_q      <= 8'h00;
            rmw_addr_q     <= 10'd0;
            rmw_data_q     <= 8'h00;
            rmw_op_q       <= 2'b00;
            rmw_old_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            lock_q         <= lock_d;
            start_cnt_q    <= start_cnt_d;
            rd_data_q      <= rd_data_d;
            rmw_addr_q     <= rmw_addr_d;
            rmw_data_q     <= rmw_data_d;
            rmw_op_q       <= rmw_op_d;
            rmw_old_q      <= rmw_old_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank) begin
            bank0_mem[wr_addr] <= wr_data;
        end
        if (wr_en && wr_bank) begin
            bank1_mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_frame_composer.sv
// tb/tb_frame_composer.sv - directed self-checking bench for frame_composer

module tb_frame_composer;

    localparam int LOCK = 100;
`ifdef FB_CLEAR_ON_SWAP_EN
    localparam int GAP   = 1026;
    localparam int QUIET = 1200;
`else
    localparam int GAP   = 100;
    localparam int QUIET = 150;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       blit_valid_i = 1'b0;
    logic       blit_ready_o;
    logic [6:0] blit_col_i = '0;
    logic [2:0] blit_page_i = '0;
    logic [7:0] blit_data_i = '0;
    logic [1:0] blit_op_i = '0;
    logic       frame_done_i = 1'b0;
    logic [9:0] rd_addr_i = '0;
    logic [7:0] rd_data_o;
    logic       start_o;
    logic       front_sel_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    frame_composer #(.LOCK_CYCLES(LOCK)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .blit_valid_i (blit_valid_i),
        .blit_ready_o (blit_ready_o),
        .blit_col_i   (blit_col_i),
        .blit_page_i  (blit_page_i),
        .blit_data_i  (blit_data_i),
        .blit_op_i    (blit_op_i),
        .frame_done_i (frame_done_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .start_o      (start_o),
        .front_sel_o  (front_sel_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_and_init(input string tag);
        int n;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        n = 0;
        while (!blit_ready_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, 2048);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!blit_ready_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, blit_ready_o, 1);
    endtask

    task automatic blit(input logic [6:0] col, input logic [2:0] page,
                        input logic [7:0] data, input logic [1:0] op);
        wait_ready("blit_wait_ready");
        blit_col_i   = col;
        blit_page_i  = page;
        blit_data_i  = data;
        blit_op_i    = op;
        blit_valid_i = 1'b1;
        @(negedge clk);
        blit_valid_i = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done_i = 1'b1;
        @(negedge clk);
        frame_done_i = 1'b0;
    endtask

    task automatic wait_swap(input string tag, output int t);
        logic fs;
        logic exp_fs;
        int   n;
        fs = front_sel_o;
        exp_fs = !fs;
        n = 0;
        while (front_sel_o == fs && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, front_sel_o, exp_fs);
        t = cyc;
    endtask

    task automatic check_start(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk(tag, start_o, 1);
            @(negedge clk);
        end
        chk(tag, start_o, 0);
    endtask

    task automatic read_chk(input string tag, input logic [9:0] addr, input logic [7:0] exp);
        rd_addr_i = addr;
        @(negedge clk);
        chk(tag, rd_data_o, exp);
    endtask

    logic [1:0] ops   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] datas [4] = '{8'hF0, 8'h0F, 8'h3C, 8'h81};

    initial begin
        int t0, t1, t2, t3, toggles;
        logic fs;

        repeat (2) @(negedge clk);
        chk("rst_front_sel", front_sel_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_ready", blit_ready_o, 0);

        reset_and_init("init_ready_latency");
        read_chk("init_rd_000", 10'h000, 8'h00);
        read_chk("init_rd_286", 10'h286, 8'h00);
        read_chk("init_rd_3ff", 10'h3FF, 8'h00);

        // Single write blit into the back bank, then swap.
        blit(7'd70, 3'd2, 8'hA5, 2'b00);
        pulse_fd();
        wait_swap("swap1_front", t0);
        chk("swap1_front_is1", front_sel_o, 1);
        check_start("swap1_start");
        read_chk("swap1_rd_286", 10'h286, 8'hA5);

        // Back-to-back RMW ops on col 5 page 0; ready must toggle 1,0 per blit.
        wait_ready("b2b_wait_ready");
        for (int i = 0; i < 4; i++) begin
            blit_col_i   = 7'd5;
            blit_page_i  = 3'd0;
            blit_data_i  = datas[i];
            blit_op_i    = ops[i];
            blit_valid_i = 1'b1;
            chk("b2b_ready_T", blit_ready_o, 1);
            @(negedge clk);
            chk("b2b_ready_T1", blit_ready_o, 0);
            @(negedge clk);
        end
        blit_valid_i = 1'b0;
        pulse_fd();
        wait_swap("swap2_front", t1);
        chk("swap2_front_is0", front_sel_o, 0);
        read_chk("b2b_result", 10'h005, 8'h42);
        read_chk("swap2_rd_286", 10'h286, 8'h00);

        // Two pulses during lockout merge into one swap.
        repeat (2) @(negedge clk);
        pulse_fd();
        repeat (9) @(negedge clk);
        pulse_fd();
        wait_swap("merge_swap", t2);
        chk("merge_gap", t2 - t1, GAP);
        repeat (19) @(negedge clk);
        pulse_fd();
        wait_swap("late_swap", t3);
        chk("late_gap", t3 - t2, GAP);
        fs = front_sel_o;
        toggles = 0;
        for (int i = 0; i < QUIET; i++) begin
            @(negedge clk);
            if (front_sel_o != fs) begin
                toggles++;
                fs = front_sel_o;
            end
        end
        chk("no_extra_swap", toggles, 0);

        // Blit accepted in the same cycle as frame_done_i.
        wait_ready("same_wait_ready");
        blit_col_i   = 7'd9;
        blit_page_i  = 3'd1;
        blit_data_i  = 8'h5A;
        blit_op_i    = 2'b00;
        blit_valid_i = 1'b1;
        frame_done_i = 1'b1;
        chk("same_ready_T", blit_ready_o, 1);
        @(negedge clk);
        blit_valid_i = 1'b0;
        frame_done_i = 1'b0;
        chk("same_ready_T1", blit_ready_o, 0);
        @(negedge clk);
        chk("same_ready_T2", blit_ready_o, 0);
        wait_swap("same_swap", t0);
        chk("same_front_is1", front_sel_o, 1);
        read_chk("same_rd_049", 10'h049, 8'h5A);
        @(negedge clk);
        chk("mid_start_high", start_o, 1);

        // Reset in the middle of the start pulse (and CLEAR when enabled).
        rstn = 1'b0;
        #1;
        chk("midrst_front_sel", front_sel_o, 0);
        chk("midrst_start", start_o, 0);
        chk("midrst_rd_data", rd_data_o, 0);
        chk("midrst_ready", blit_ready_o, 0);
        reset_and_init("reinit_ready_latency");
        read_chk("reinit_b0_005", 10'h005, 8'h00);
        read_chk("reinit_b0_049", 10'h049, 8'h00);
        pulse_fd();
        wait_swap("reinit_swap", t1);
        chk("reinit_front_is1", front_sel_o, 1);
        read_chk("reinit_b1_049", 10'h049, 8'h00);
        read_chk("reinit_b1_286", 10'h286, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
